// File: rtl/recorder_ctrl.sv
// recorder_ctrl: SRAM audio record/playback controller with pause and
// variable-speed (fast skip / slow repeat) playback.
module recorder_ctrl #(
  parameter int ADDR_W = 18,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              record_btn,
  input  logic              pause_btn,
  input  logic [3:0]        speed_sw,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_stb,
  output logic              rd_stb,
  output logic [ADDR_W-1:0] end_addr,
  output logic [2:0]        mode,
  output logic              done
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, RECORD = 3'd1, PLAY = 3'd2, PAUSE_REC = 3'd3, PAUSE_PLAY = 3'd4
  } state_t;
  state_t state, nxt;
  logic has_rec, clr, fin, tick_ok, pause_w, rec_w, play_w, slow, adv, over, rec_end;
  logic [3:0] cnt, factor;
  logic [ADDR_W:0] sum;
  assign pause_w = pause_btn & ~stop_btn;
  assign rec_w   = record_btn & ~stop_btn & ~pause_btn;
  assign play_w  = play_btn & ~stop_btn & ~pause_btn & ~record_btn;
  assign factor  = {1'b0, speed_sw[2:0]} + 4'd1;
  assign slow    = speed_sw[3];
  assign adv     = !slow || (cnt + 4'd1 >= factor);
  // one extra bit so an address wrap counts as running past end_addr
  assign sum     = {1'b0, addr} + (slow ? (ADDR_W+1)'(1) : (ADDR_W+1)'(factor));
  assign over    = state == PLAY && rd_stb && adv && sum > {1'b0, end_addr};
  assign rec_end = state == RECORD && wr_stb && addr == MAX_ADDR;
  assign tick_ok = sample_tick && nxt == state;
  assign mode    = state;
  always_comb begin
    nxt = state;
    clr = 1'b0;
    fin = 1'b0;
    if (stop_btn || rec_end) nxt = IDLE;
    else if (pause_w && (state == RECORD || state == PAUSE_REC))
      nxt = state == RECORD ? PAUSE_REC : RECORD;
    else if (pause_w && (state == PLAY || state == PAUSE_PLAY))
      nxt = state == PLAY ? PAUSE_PLAY : PLAY;
    else if (rec_w && (state == IDLE || state == PLAY || state == PAUSE_PLAY)) begin
      nxt = RECORD;
      clr = 1'b1;
    end else if (play_w && state == IDLE && has_rec) begin
      nxt = PLAY;
      clr = 1'b1;
    end else if (over) begin
      nxt = IDLE;
      fin = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      end_addr <= '0;
      has_rec  <= 1'b0;
      cnt      <= '0;
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= nxt;
      wr_stb <= tick_ok && state == RECORD;
      rd_stb <= tick_ok && state == PLAY;
      done   <= fin || (tick_ok && state == RECORD && addr == MAX_ADDR);
      if (clr) begin
        addr <= '0;
        cnt  <= '0;
        if (nxt == RECORD) has_rec <= 1'b0;
      end else if (wr_stb) begin
        end_addr <= addr;
        addr     <= addr + ADDR_W'(1);
        has_rec  <= 1'b1;
      end else if (rd_stb && !over) begin
        if (adv) begin
          addr <= sum[ADDR_W-1:0];
          cnt  <= '0;
        end else cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_recorder_ctrl.sv
// tb_recorder_ctrl: directed scenarios for recorder_ctrl with a small
// address space (MAX_ADDR=7) so the end-of-memory case is reachable.
module tb_recorder_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic play_btn = 1'b0, stop_btn = 1'b0, record_btn = 1'b0, pause_btn = 1'b0;
  logic [3:0] speed_sw = 4'd0;
  logic sample_tick = 1'b0;
  logic [3:0] addr, end_addr;
  logic wr_stb, rd_stb, done;
  logic [2:0] mode;
  int n_chk = 0, n_pass = 0;
  int wq[$], rq[$];
  int dn = 0, dn_wr = -1;
  int wb, rb, db;

  recorder_ctrl #(.ADDR_W(4), .MAX_ADDR(4'd7)) dut (
    .clk(clk), .reset(reset), .play_btn(play_btn), .stop_btn(stop_btn),
    .record_btn(record_btn), .pause_btn(pause_btn), .speed_sw(speed_sw),
    .sample_tick(sample_tick), .addr(addr), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .end_addr(end_addr), .mode(mode), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) wq.push_back(int'(addr));
    if (rd_stb) rq.push_back(int'(addr));
    if (done) begin
      dn++;
      if (wr_stb) dn_wr = int'(addr);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic seq_chk(input string tag, input int got[$], input int base, input int exp[$]);
    chk({tag, " count"}, got.size() - base, exp.size());
    foreach (exp[i])
      chk($sformatf("%s[%0d]", tag, i), (base + i < got.size()) ? got[base + i] : -1, exp[i]);
  endtask

  // {stop, pause, record, play} held for one clock
  task automatic press(input logic [3:0] b);
    {stop_btn, pause_btn, record_btn, play_btn} = b;
    @(posedge clk); #1;
    {stop_btn, pause_btn, record_btn, play_btn} = 4'b0000;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    wb = wq.size(); rb = rq.size(); db = dn;
  endtask

  localparam logic [3:0] STOP = 4'b1000, PAUSE = 4'b0100, REC = 4'b0010, PLY = 4'b0001;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst mode", mode, 0);
    chk("rst addr", addr, 0);
    chk("rst end_addr", end_addr, 0);
    chk("rst strobes", {wr_stb, rd_stb, done}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    press(PLY);
    chk("play without recording", mode, 0);

    mark();
    press(REC);
    chk("enter record", mode, 1);
    tick(5);
    press(STOP);
    seq_chk("rec5 writes", wq, wb, '{0, 1, 2, 3, 4});
    chk("rec5 end_addr", end_addr, 4);
    chk("rec5 mode", mode, 0);

    mark();
    speed_sw = 4'b0001;
    press(PLY);
    chk("enter play", mode, 2);
    tick(5);
    seq_chk("fast x2 reads", rq, rb, '{0, 2, 4});
    chk("fast x2 done", dn - db, 1);
    chk("fast x2 mode", mode, 0);

    mark();
    press(REC);
    tick(3);
    chk("pre-pause addr", addr, 3);
    press(PAUSE);
    chk("pause_rec mode", mode, 3);
    tick(4);
    chk("paused no writes", wq.size() - wb, 3);
    press(PAUSE);
    chk("resume mode", mode, 1);
    tick(1);
    press(STOP);
    seq_chk("pause writes", wq, wb, '{0, 1, 2, 3});
    chk("no rd while recording", rq.size() - rb, 0);

    press(REC);
    tick(2);
    press(STOP);
    chk("short rec end_addr", end_addr, 1);
    mark();
    speed_sw = 4'b1010;
    press(PLY);
    tick(8);
    seq_chk("slow x3 reads", rq, rb, '{0, 0, 0, 1, 1, 1});
    chk("slow x3 done", dn - db, 1);
    chk("slow x3 mode", mode, 0);

    press(REC);
    tick(3);
    press(STOP);
    speed_sw = 4'b0000;
    press(PLY);
    tick(1);
    press(REC);
    chk("rec in play mode", mode, 1);
    chk("rec in play addr", addr, 0);
    press(STOP);
    press(REC);
    tick(3);
    press(STOP);
    press(PLY);
    tick(1);
    mark();
    press(STOP | REC);
    chk("stop+rec mode", mode, 0);
    tick(1);
    chk("stop+rec no wr", wq.size() - wb, 0);
    chk("stop+rec no rd", rq.size() - rb, 0);

    mark();
    press(REC);
    tick(9);
    seq_chk("max writes", wq, wb, '{0, 1, 2, 3, 4, 5, 6, 7});
    chk("max done", dn - db, 1);
    chk("max done with write at", dn_wr, 7);
    chk("max mode", mode, 0);
    chk("max end_addr", end_addr, 7);

    speed_sw = 4'b0001;
    press(PLY);
    tick(2);
    chk("pre-reset addr", addr, 4);
    sample_tick = 1'b1;
    @(posedge clk); #2;
    sample_tick = 1'b0;
    chk("pre-reset rd_stb", rd_stb, 1);
    reset = 1'b1;
    #1;
    chk("async rst mode", mode, 0);
    chk("async rst addr", addr, 0);
    chk("async rst end_addr", end_addr, 0);
    chk("async rst strobes", {wr_stb, rd_stb, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    press(PLY);
    chk("play after reset", mode, 0);
    tick(1);
    chk("no rd after reset", rq.size() - rb, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
